// File: rtl/dcnt_sched_pkg.sv
// Shared definitions for the countdown scheduler: state encoding and default width.
package dcnt_sched_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/dcnt_core.sv
// Loadable down-counter: load wins over enable, and the count stops at zero.
module dcnt_core
    import dcnt_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next count: preset load, else decrement unless already at the terminal zero
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = din;
        end else if (en && (q_q != '0)) begin
            q_d = q_q - WIDTH'(1);
        end
    end

    // Count register, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dcnt_sched.sv
// Two-requester round-robin scheduler sharing one countdown counter.
module dcnt_sched
    import dcnt_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             hold,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] q
);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             last_q, last_d;   // index of the requester served most recently
    logic             win;
    logic             ld;
    logic             en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] cnt;

    // The preset always comes from whichever requester currently holds the grant
    assign din = gnt_q[1] ? d1 : d0;

    dcnt_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .rst (rst),
        .ld  (ld),
        .en  (en),
        .din (din),
        .q   (cnt)
    );

    // Next-state, arbitration and counter control
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        last_d  = last_q;
        win     = 1'b0;
        ld      = 1'b0;
        en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    // On contention the requester not served last time wins
                    win     = (req == 2'b11) ? ~last_q : req[1];
                    gnt_d   = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld      = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt == '0) begin
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end else begin
                    en = ~hold;
                end
            end
            ST_DONE: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, completion and last-served registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);
    assign q    = cnt;

endmodule

// File: tb/tb_dcnt_sched.sv
// Directed bench for dcnt_sched: reset, single service, contention, hold,
// zero preset, full-range countdown and reset in the middle of a run.
module tb_dcnt_sched;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             hold;
    logic [1:0]       gnt;
    logic             busy;
    logic [1:0]       done;
    logic [WIDTH-1:0] q;

    int n_checks = 0;
    int n_errors = 0;

    dcnt_sched #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .d0   (d0),
        .d1   (d1),
        .hold (hold),
        .gnt  (gnt),
        .busy (busy),
        .done (done),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".gnt"},  32'(gnt),  32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
    endtask

    // Follows one complete service with hold low; req must already be applied
    // at a falling edge while the scheduler is idle.
    task automatic service(input string tag, input logic [1:0] g, input int n);
        @(negedge clk);
        check({tag, ".gnt"},  32'(gnt),  32'(g));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".done"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, ".preset"}, 32'(q), 32'(n));
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check({tag, ".q"},    32'(q),    32'(n - k));
            check({tag, ".rgnt"}, 32'(gnt),  32'(g));
            check({tag, ".rdone"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        check({tag, ".done"},  32'(done), 32'(g));
        check({tag, ".dgnt"},  32'(gnt),  32'(g));
        check({tag, ".dq"},    32'(q),    32'd0);
        @(negedge clk);
        check_idle({tag, ".end"});
        check({tag, ".endq"}, 32'(q), 32'd0);
    endtask

    initial begin
        rst  = 1'b0;
        req  = 2'b00;
        d0   = '0;
        d1   = '0;
        hold = 1'b0;

        // Reset values before any clock edge
        #1;
        check_idle("rst0");
        check("rst0.q", 32'(q), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("idle");

        // Contention with both requests held: 0,1,0,1
        req = 2'b11; d0 = 4'd2; d1 = 4'd4;
        service("rr0a", 2'b01, 2);
        service("rr1a", 2'b10, 4);
        service("rr0b", 2'b01, 2);
        service("rr1b", 2'b10, 4);
        req = 2'b00;

        // Single request from requester 0
        @(negedge clk);
        req = 2'b01; d0 = 4'd3;
        service("single", 2'b01, 3);
        req = 2'b00;

        // Hold for three cycles at q=3
        @(negedge clk);
        req = 2'b10; d1 = 4'd5;
        @(negedge clk);
        req = 2'b00;
        check("hold.gnt", 32'(gnt), 32'd2);
        @(negedge clk); check("hold.q5", 32'(q), 32'd5);
        @(negedge clk); check("hold.q4", 32'(q), 32'd4);
        @(negedge clk); check("hold.q3", 32'(q), 32'd3);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold.stay", 32'(q), 32'd3);
            check("hold.sdone", 32'(done), 32'd0);
        end
        hold = 1'b0;
        @(negedge clk); check("hold.q2", 32'(q), 32'd2);
        @(negedge clk); check("hold.q1", 32'(q), 32'd1);
        @(negedge clk); check("hold.q0", 32'(q), 32'd0);
        @(negedge clk); check("hold.done", 32'(done), 32'd2);
        @(negedge clk); check_idle("hold.end");

        // Zero-length countdown from requester 1
        req = 2'b10; d1 = 4'd0;
        service("zero", 2'b10, 0);
        req = 2'b00;

        // Full-range countdown; a request change mid-run must not disturb it
        @(negedge clk);
        req = 2'b01; d0 = 4'd15;
        fork
            service("sat", 2'b01, 15);
            begin
                repeat (6) @(negedge clk);
                req = 2'b10;
                d0  = 4'd7;
            end
        join
        req = 2'b00;

        // Reset while counting at q=5: everything clears, no completion pulse
        @(negedge clk);
        req = 2'b01; d0 = 4'd9;
        @(negedge clk);
        req = 2'b00;
        repeat (5) @(negedge clk);
        check("mid.q5", 32'(q), 32'd5);
        rst = 1'b0;
        #1;
        check_idle("mid.rst");
        check("mid.q", 32'(q), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("mid.hdone", 32'(done), 32'd0);
            check("mid.hq", 32'(q), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid.rel");

        // After reset requester 0 regains priority under contention
        req = 2'b11; d0 = 4'd1; d1 = 4'd1;
        service("prio", 2'b01, 1);
        req = 2'b00;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcnt_sched.md
DCNT_SCHED -- requirements
Module: dcnt_sched

Interface
REQ-001 Parameter WIDTH, default 4, counter and preset width.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-004 Port req  input  2  per-requester service request, bit i = requester i.
REQ-005 Port d0  input  WIDTH  preset value from requester 0.
REQ-006 Port d1  input  WIDTH  preset value from requester 1.
REQ-007 Port hold  input  1  pause countdown while high.
REQ-008 Port gnt  output  2  one-hot grant, registered.
REQ-009 Port busy  output  1  high whenever state is not IDLE.
REQ-010 Port done  output  2  one-cycle completion pulse, bit i = requester i.
REQ-011 Port q  output  WIDTH  current shared counter value.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, RUN, DONE; single state register.
REQ-013 IDLE: req==0 -> stay IDLE; req!=0 -> LOAD next edge, gnt set to the winner, winner recorded as last-served.
REQ-014 Arbitration SHALL be round-robin: single request wins outright; both requests -> requester not last served wins; after reset requester 0 has priority.
REQ-015 req SHALL be sampled only in IDLE; changes to req during LOAD/RUN/DONE are ignored; no abort.
REQ-016 LOAD: q <= preset of granted requester (d0 or d1 sampled this cycle), next state RUN, regardless of hold.
REQ-017 RUN, q!=0, hold=0: q <= q-1, stay RUN.
REQ-018 RUN, q!=0, hold=1: q and state unchanged.
REQ-019 RUN, q==0: next state DONE, q stays 0, hold ignored.
REQ-020 Counter SHALL never wrap; 0 is terminal, no decrement below 0.
REQ-021 Preset 0: LOAD -> RUN with q=0 -> DONE next edge (zero-length countdown).
REQ-022 DONE: done[granted]=1 for exactly this cycle, gnt still held; next state IDLE, gnt cleared on that edge.
REQ-023 Latency, hold=0, preset N: gnt asserts edge t, q=N after edge t+1, q=0 after edge t+1+N, DONE during cycle t+2+N, IDLE after edge t+3+N.
REQ-024 Back-to-back: request pending in IDLE after DONE SHALL be granted on the first IDLE cycle (one IDLE cycle minimum between services).
REQ-025 busy SHALL equal (state!=IDLE), combinational from state register.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, q=0, gnt=00, done=00, busy=0, last-served=requester 1 (so requester 0 has priority), independent of clk.
REQ-027 Reset asserted mid-RUN SHALL discard the operation with no done pulse; after release, servicing restarts from IDLE.
REQ-028 Release of rst SHALL take effect at the next rising edge; no output glitches beyond the reset values.

Structure
REQ-029 Shared package SHALL hold the state encoding constants (IDLE=00, LOAD=01, RUN=10, DONE=11) and default WIDTH.
REQ-030 Counter datapath SHALL be a sub-module dcnt_core (inputs clk, rst, ld, en, din; output q): load has priority over enable, saturates at 0.
REQ-031 Arbiter, FSM and grant/done registers SHALL reside in dcnt_sched.

Verification
REQ-032 Reset: rst=0 mid-count at q=5 -> q=0, gnt=00, busy=0 immediately; no done pulse.
REQ-033 Single request: req=01, d0=0011, hold=0 -> gnt=01, q 3,2,1,0, done=01 pulse in cycle t+5, back to IDLE.
REQ-034 Contention: req=11 held, d0=0010, d1=0100 -> grant order 0,1,0,1; done pulses alternate 01,10.
REQ-035 Hold: d1=0101, hold=1 for 3 cycles at q=3 -> q stays 3 for 3 cycles, done delayed by 3 cycles.
REQ-036 Zero preset: req=10, d1=0000 -> done=10 in cycle t+2; q remains 0.
REQ-037 Saturation: d0=1111 full run -> q descends 15..0, never wraps to 1111, req changes during RUN ignored.
